// File: rtl/ps2_pkg.sv
// Shared state encoding, PS/2 protocol byte constants and error codes for the
// PS/2 initialisation sequencer.
package ps2_pkg;

  typedef enum logic [3:0] {
    ST_IDLE     = 4'd0,
    ST_SEND     = 4'd1,
    ST_WAIT_TX  = 4'd2,
    ST_WAIT_ACK = 4'd3,
    ST_WAIT_BAT = 4'd4,
    ST_WAIT_ID  = 4'd5,
    ST_READY    = 4'd6,
    ST_HOST_TX  = 4'd7,
    ST_HOST_ACK = 4'd8,
    ST_ERROR    = 4'd9
  } ps2_state_e;

  localparam logic [7:0] PS2_CMD_RESET    = 8'hFF;
  localparam logic [7:0] PS2_RSP_ACK      = 8'hFA;
  localparam logic [7:0] PS2_RSP_RESEND   = 8'hFE;
  localparam logic [7:0] PS2_RSP_BAT_OK   = 8'hAA;
  localparam logic [7:0] PS2_RSP_BAT_FAIL = 8'hFC;

  localparam logic [2:0] ERR_NONE         = 3'd0;
  localparam logic [2:0] ERR_TX_TIMEOUT   = 3'd1;
  localparam logic [2:0] ERR_RESP_TIMEOUT = 3'd2;
  localparam logic [2:0] ERR_RETRIES      = 3'd3;
  localparam logic [2:0] ERR_BAD_BYTE     = 3'd4;

  // States in which the device owes us a response byte.
  function automatic logic is_resp_state(input ps2_state_e s);
    return (s == ST_WAIT_ACK) || (s == ST_WAIT_BAT) ||
           (s == ST_WAIT_ID)  || (s == ST_HOST_ACK);
  endfunction

endpackage

// File: rtl/ps2_resp_timer.sv
// Response timeout counter: synchronous clear, count enable and a terminal-count
// flag raised on the CLOCK_CYCLES_FOR_RESP-th enabled cycle after a clear.
module ps2_resp_timer #(
  parameter int unsigned CLOCK_CYCLES_FOR_RESP = 50000000,
  parameter int unsigned DATA_WIDTH_FOR_RESP   = 26
) (
  input  logic clk,
  input  logic reset,
  input  logic clear,
  input  logic enable,
  output logic timed_out
);

  localparam logic [DATA_WIDTH_FOR_RESP-1:0] LAST =
    DATA_WIDTH_FOR_RESP'(CLOCK_CYCLES_FOR_RESP - 1);

  logic [DATA_WIDTH_FOR_RESP-1:0] count;

  always_ff @(posedge clk) begin
    if (reset || clear) begin
      count <= '0;
    end else if (enable && (count != LAST)) begin
      count <= count + DATA_WIDTH_FOR_RESP'(1);
    end
  end

  assign timed_out = enable && (count == LAST);

endmodule

// File: rtl/ps2_init_sequencer.sv
// Sequences a PS/2 transceiver through device reset/enable, then forwards the
// device byte stream and arbitrates single host commands onto the transceiver.
module ps2_init_sequencer
  import ps2_pkg::*;
#(
  parameter logic [7:0]  ENABLE_CMD            = 8'hF4,
  parameter bit          EXPECT_ID             = 1'b1,
  parameter int unsigned MAX_RETRIES           = 3,
  parameter int unsigned CLOCK_CYCLES_FOR_RESP = 50000000,
  parameter int unsigned DATA_WIDTH_FOR_RESP   = 26
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       start,
  input  logic [7:0] host_command,
  input  logic       host_send,
  output logic [7:0] the_command,
  output logic       send_command,
  input  logic       command_was_sent,
  input  logic       error_communication_timed_out,
  input  logic [7:0] received_data,
  input  logic       received_data_en,
  output logic       init_busy,
  output logic       init_done,
  output logic       init_error,
  output logic [2:0] error_code,
  output logic       host_ack,
  output logic [7:0] data_out,
  output logic       data_valid
);

  ps2_state_e state_q, state_d;
  logic [7:0] cmd_q, cmd_d;
  logic [7:0] retry_q, retry_d;
  logic [7:0] the_command_d;
  logic       send_command_d;
  logic [2:0] error_code_d;
  logic       host_ack_d;
  logic [7:0] data_out_d;
  logic       data_valid_d;
  logic       resp_timed_out;

  ps2_resp_timer #(
    .CLOCK_CYCLES_FOR_RESP(CLOCK_CYCLES_FOR_RESP),
    .DATA_WIDTH_FOR_RESP  (DATA_WIDTH_FOR_RESP)
  ) u_resp_timer (
    .clk      (clk),
    .reset    (reset),
    .clear    (state_d != state_q),
    .enable   (is_resp_state(state_q)),
    .timed_out(resp_timed_out)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= ST_IDLE;
      cmd_q        <= '0;
      retry_q      <= '0;
      the_command  <= '0;
      send_command <= 1'b0;
      error_code   <= ERR_NONE;
      host_ack     <= 1'b0;
      data_out     <= '0;
      data_valid   <= 1'b0;
    end else begin
      state_q      <= state_d;
      cmd_q        <= cmd_d;
      retry_q      <= retry_d;
      the_command  <= the_command_d;
      send_command <= send_command_d;
      error_code   <= error_code_d;
      host_ack     <= host_ack_d;
      data_out     <= data_out_d;
      data_valid   <= data_valid_d;
    end
  end

  always_comb begin
    state_d        = state_q;
    cmd_d          = cmd_q;
    retry_d        = retry_q;
    the_command_d  = the_command;
    send_command_d = send_command;
    error_code_d   = error_code;
    host_ack_d     = 1'b0;
    data_out_d     = data_out;
    data_valid_d   = 1'b0;

    unique case (state_q)
      ST_IDLE: begin
        if (start) begin
          state_d = ST_SEND;
          cmd_d   = PS2_CMD_RESET;
          retry_d = '0;
        end
      end
      ST_SEND: begin
        the_command_d  = cmd_q;
        send_command_d = 1'b1;
        state_d        = ST_WAIT_TX;
      end
      ST_WAIT_TX: begin
        if (error_communication_timed_out) begin
          send_command_d = 1'b0;
          error_code_d   = ERR_TX_TIMEOUT;
          state_d        = ST_ERROR;
        end else if (command_was_sent) begin
          send_command_d = 1'b0;
          state_d        = ST_WAIT_ACK;
        end
      end
      ST_WAIT_ACK: begin
        if (received_data_en) begin
          if (received_data == PS2_RSP_ACK) begin
            state_d = (cmd_q == PS2_CMD_RESET) ? ST_WAIT_BAT : ST_READY;
          end else if (received_data == PS2_RSP_RESEND) begin
            // retry_q counts resends already issued; the one that would reach
            // MAX_RETRIES is refused.
            if (retry_q + 8'd1 >= 8'(MAX_RETRIES)) begin
              error_code_d = ERR_RETRIES;
              state_d      = ST_ERROR;
            end else begin
              retry_d = retry_q + 8'd1;
              state_d = ST_SEND;
            end
          end else begin
            error_code_d = ERR_BAD_BYTE;
            state_d      = ST_ERROR;
          end
        end else if (resp_timed_out) begin
          error_code_d = ERR_RESP_TIMEOUT;
          state_d      = ST_ERROR;
        end
      end
      ST_WAIT_BAT: begin
        if (received_data_en) begin
          if (received_data == PS2_RSP_BAT_OK) begin
            if (EXPECT_ID) begin
              state_d = ST_WAIT_ID;
            end else begin
              state_d = ST_SEND;
              cmd_d   = ENABLE_CMD;
              retry_d = '0;
            end
          end else begin
            error_code_d = ERR_BAD_BYTE;
            state_d      = ST_ERROR;
          end
        end else if (resp_timed_out) begin
          error_code_d = ERR_RESP_TIMEOUT;
          state_d      = ST_ERROR;
        end
      end
      ST_WAIT_ID: begin
        if (received_data_en) begin
          state_d = ST_SEND;
          cmd_d   = ENABLE_CMD;
          retry_d = '0;
        end else if (resp_timed_out) begin
          error_code_d = ERR_RESP_TIMEOUT;
          state_d      = ST_ERROR;
        end
      end
      ST_READY: begin
        if (received_data_en) begin
          data_valid_d = 1'b1;
          data_out_d   = received_data;
        end
        if (start) begin
          state_d = ST_SEND;
          cmd_d   = PS2_CMD_RESET;
          retry_d = '0;
        end else if (host_send) begin
          the_command_d  = host_command;
          send_command_d = 1'b1;
          state_d        = ST_HOST_TX;
        end
      end
      ST_HOST_TX: begin
        if (error_communication_timed_out) begin
          send_command_d = 1'b0;
          state_d        = ST_READY;
        end else if (command_was_sent) begin
          send_command_d = 1'b0;
          state_d        = ST_HOST_ACK;
        end
      end
      ST_HOST_ACK: begin
        if (received_data_en) begin
          if (received_data == PS2_RSP_ACK) begin
            host_ack_d = 1'b1;
            state_d    = ST_READY;
          end else if (received_data == PS2_RSP_RESEND) begin
            state_d = ST_READY;
          end else begin
            data_valid_d = 1'b1;
            data_out_d   = received_data;
          end
        end else if (resp_timed_out) begin
          state_d = ST_READY;
        end
      end
      ST_ERROR: begin
        if (start) begin
          error_code_d = ERR_NONE;
          state_d      = ST_SEND;
          cmd_d        = PS2_CMD_RESET;
          retry_d      = '0;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  assign init_busy  = (state_q != ST_IDLE) && (state_q != ST_READY) && (state_q != ST_ERROR);
  assign init_done  = (state_q == ST_READY);
  assign init_error = (state_q == ST_ERROR);

endmodule

// File: tb/tb_ps2_init_sequencer.sv
// Self-checking bench: a scripted PS/2 device plus a transaction-level model of
// the expected command sequence, final status and forwarded byte stream.
module tb_ps2_init_sequencer;

  localparam int unsigned MAXR = 3;
  localparam int unsigned RESP = 100;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       start = 1'b0;
  logic [7:0] host_command = 8'h00;
  logic       host_send = 1'b0;
  logic       command_was_sent = 1'b0;
  logic       error_communication_timed_out = 1'b0;
  logic [7:0] received_data = 8'h00;
  logic       received_data_en = 1'b0;
  logic [7:0] the_command;
  logic       send_command;
  logic       init_busy, init_done, init_error;
  logic [2:0] error_code;
  logic       host_ack;
  logic [7:0] data_out;
  logic       data_valid;

  ps2_init_sequencer #(
    .ENABLE_CMD           (8'hF4),
    .EXPECT_ID            (1'b1),
    .MAX_RETRIES          (MAXR),
    .CLOCK_CYCLES_FOR_RESP(RESP),
    .DATA_WIDTH_FOR_RESP  (8)
  ) dut (
    .clk                          (clk),
    .reset                        (reset),
    .start                        (start),
    .host_command                 (host_command),
    .host_send                    (host_send),
    .the_command                  (the_command),
    .send_command                 (send_command),
    .command_was_sent             (command_was_sent),
    .error_communication_timed_out(error_communication_timed_out),
    .received_data                (received_data),
    .received_data_en             (received_data_en),
    .init_busy                    (init_busy),
    .init_done                    (init_done),
    .init_error                   (init_error),
    .error_code                   (error_code),
    .host_ack                     (host_ack),
    .data_out                     (data_out),
    .data_valid                   (data_valid)
  );

  always #5 clk = ~clk;

  int         n_checks = 0;
  int         n_pass = 0;
  int         ack_seen = 0;
  int         acks_exp = 0;
  logic [7:0] sent_q[$];
  logic [7:0] exp_cmds[$];
  logic [7:0] exp_fwd_q[$];
  int         exp_code = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  // Expected command stream and final error code for one init attempt.
  // fault: 0 none, 1 tx timeout on first send, 2 BAT fail, 3 silent after ACK of FF, 4 bad ACK to enable.
  function automatic void model_init(input int fe_ff, input int fe_en, input int fault);
    exp_cmds.delete();
    exp_code = 0;
    if (fault == 1) begin exp_cmds.push_back(8'hFF); exp_code = 1; return; end
    for (int i = 0; i <= fe_ff && i < int'(MAXR); i++) exp_cmds.push_back(8'hFF);
    if (fe_ff >= int'(MAXR)) begin exp_code = 3; return; end
    if (fault == 3) begin exp_code = 2; return; end
    if (fault == 2) begin exp_code = 4; return; end
    for (int i = 0; i <= fe_en && i < int'(MAXR); i++) exp_cmds.push_back(8'hF4);
    if (fe_en >= int'(MAXR)) begin exp_code = 3; return; end
    if (fault == 4) exp_code = 4;
  endfunction

  logic       prev_send = 1'b0;
  logic [7:0] prev_cmd = 8'h00;
  logic [7:0] fwd_exp;

  always @(negedge clk) begin
    if (!reset) begin
      if (data_valid) begin
        check("fwd_queue_nonempty", 32'(exp_fwd_q.size() != 0), 32'd1);
        if (exp_fwd_q.size() != 0) begin
          fwd_exp = exp_fwd_q.pop_front();
          check("fwd_byte", 32'(data_out), 32'(fwd_exp));
        end
      end
      if (host_ack) ack_seen++;
      if (send_command && prev_send) check("cmd_stable", 32'(the_command), 32'(prev_cmd));
      check("status_onehot",
            32'({init_busy, init_done, init_error} inside {3'b000, 3'b100, 3'b010, 3'b001}), 32'd1);
    end
    prev_send = send_command;
    prev_cmd  = the_command;
  end

  task automatic serve(input int max_wait, input bit tx_fail, output bit got, output logic [7:0] cmd);
    got = 1'b0;
    cmd = 8'h00;
    for (int i = 0; i < max_wait; i++) begin
      @(negedge clk);
      if (send_command) begin got = 1'b1; break; end
    end
    if (!got) return;
    cmd = the_command;
    sent_q.push_back(cmd);
    repeat ($urandom_range(1, 4)) @(posedge clk);
    #1;
    if (tx_fail) error_communication_timed_out = 1'b1;
    else command_was_sent = 1'b1;
    @(posedge clk);
    @(negedge clk);
    check("send_drop", 32'(send_command), 32'd0);
    command_was_sent = 1'b0;
    error_communication_timed_out = 1'b0;
  endtask

  task automatic reply(input logic [7:0] b);
    @(posedge clk); #1;
    received_data = b;
    received_data_en = 1'b1;
    @(posedge clk); #1;
    received_data_en = 1'b0;
    received_data = 8'($urandom);
  endtask

  task automatic pulse_start(input bit with_host);
    @(posedge clk); #1;
    start = 1'b1;
    if (with_host) begin host_send = 1'b1; host_command = 8'hED; end
    @(posedge clk); #1;
    start = 1'b0;
    host_send = 1'b0;
  endtask

  task automatic run_init(input int fe_ff, input int fe_en, input int fault,
                          input logic [7:0] idb, input bit with_host);
    int ffc = 0;
    int enc = 0;
    int cyc;
    bit got;
    logic [7:0] cmd;
    sent_q.delete();
    model_init(fe_ff, fe_en, fault);
    pulse_start(with_host);
    for (int a = 0; a < 10; a++) begin
      serve(60, fault == 1, got, cmd);
      if (!got || fault == 1) break;
      if (cmd == 8'hFF) begin
        if (ffc < fe_ff) begin
          ffc++;
          reply(8'hFE);
        end else begin
          reply(8'hFA);
          if (fault == 3) begin
            cyc = 0;
            while (!init_error && cyc < 400) begin @(posedge clk); cyc++; #1; end
            check("resp_timeout_cycles", 32'(cyc), 32'(RESP));
            break;
          end
          reply(fault == 2 ? 8'hFC : 8'hAA);
          if (fault == 2) break;
          reply(idb);
        end
      end else begin
        if (enc < fe_en) begin
          enc++;
          reply(8'hFE);
        end else begin
          reply(fault == 4 ? 8'h12 : 8'hFA);
          break;
        end
      end
    end
    repeat (2) @(negedge clk);
    check("cmd_count", 32'(sent_q.size()), 32'(exp_cmds.size()));
    for (int i = 0; i < sent_q.size() && i < exp_cmds.size(); i++)
      check("cmd_byte", 32'(sent_q[i]), 32'(exp_cmds[i]));
    check("init_done", 32'(init_done), 32'(exp_code == 0));
    check("init_error", 32'(init_error), 32'(exp_code != 0));
    check("error_code", 32'(error_code), 32'(exp_code));
    check("init_busy_end", 32'(init_busy), 32'd0);
  endtask

  task automatic fwd_byte(input logic [7:0] b);
    exp_fwd_q.push_back(b);
    @(posedge clk); #1;
    received_data = b;
    received_data_en = 1'b1;
    @(posedge clk); #1;
    received_data_en = 1'b0;
    @(negedge clk);
    check("fwd_latency", 32'(data_valid), 32'd1);
    check("fwd_latency_data", 32'(data_out), 32'(b));
  endtask

  // outcome: 0 ACK, 1 resend, 2 stray byte then ACK, 3 transmit timeout
  task automatic host_cmd(input logic [7:0] c, input int outcome);
    bit got;
    logic [7:0] cmd;
    logic [7:0] b;
    @(posedge clk); #1;
    host_command = c;
    host_send = 1'b1;
    @(posedge clk); #1;
    host_send = 1'b0;
    serve(20, outcome == 3, got, cmd);
    check("host_cmd_sent", 32'(got), 32'd1);
    check("host_cmd_byte", 32'(cmd), 32'(c));
    if (got) begin
      case (outcome)
        0: begin acks_exp++; reply(8'hFA); end
        1: reply(8'hFE);
        2: begin
          b = 8'($urandom);
          while (b == 8'hFA || b == 8'hFE) b = 8'($urandom);
          exp_fwd_q.push_back(b);
          reply(b);
          acks_exp++;
          reply(8'hFA);
        end
        default: ;
      endcase
    end
    repeat (2) @(negedge clk);
    #1;
    check("host_ack_count", 32'(ack_seen), 32'(acks_exp));
    check("ready_after_host", 32'(init_done), 32'd1);
  endtask

  initial begin
    bit got;
    logic [7:0] cmd;
    int fault;

    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_send_command", 32'(send_command), 32'd0);
    check("rst_the_command", 32'(the_command), 32'd0);
    check("rst_busy", 32'(init_busy), 32'd0);
    check("rst_done", 32'(init_done), 32'd0);
    check("rst_error", 32'(init_error), 32'd0);
    check("rst_error_code", 32'(error_code), 32'd0);
    check("rst_host_ack", 32'(host_ack), 32'd0);
    check("rst_data_valid", 32'(data_valid), 32'd0);
    @(posedge clk); #1;
    reset = 1'b0;

    run_init(0, 0, 0, 8'h00, 1'b0);
    check("clean_len", 32'(sent_q.size()), 32'd2);
    check("clean_first", 32'(sent_q[0]), 32'hFF);
    check("clean_second", 32'(sent_q[1]), 32'hF4);

    run_init(2, 0, 0, 8'h00, 1'b0);
    check("resend2_len", 32'(sent_q.size()), 32'd4);
    check("resend2_third", 32'(sent_q[2]), 32'hFF);
    check("resend2_done", 32'(init_done), 32'd1);

    run_init(3, 0, 0, 8'h00, 1'b0);
    check("resend3_code", 32'(error_code), 32'd3);

    run_init(0, 0, 1, 8'h00, 1'b0);
    check("txto_code", 32'(error_code), 32'd1);

    run_init(0, 0, 2, 8'h00, 1'b0);
    check("batfail_code", 32'(error_code), 32'd4);

    run_init(0, 0, 3, 8'h00, 1'b0);
    check("respto_code", 32'(error_code), 32'd2);

    pulse_start(1'b0);
    got = 1'b0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (send_command) begin got = 1'b1; break; end
    end
    check("wait_tx_reached", 32'(got), 32'd1);
    @(posedge clk); #1;
    reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    @(negedge clk);
    check("rst_mid_send", 32'(send_command), 32'd0);
    check("rst_mid_busy", 32'(init_busy), 32'd0);
    check("rst_mid_error_code", 32'(error_code), 32'd0);

    // host_send while waiting for BAT must not reach the wire
    sent_q.delete();
    pulse_start(1'b0);
    serve(60, 1'b0, got, cmd);
    reply(8'hFA);
    @(posedge clk); #1;
    host_command = 8'hED;
    host_send = 1'b1;
    @(posedge clk); #1;
    host_send = 1'b0;
    reply(8'hAA);
    reply(8'h00);
    serve(60, 1'b0, got, cmd);
    check("bat_host_cmd", 32'(cmd), 32'hF4);
    reply(8'hFA);
    repeat (2) @(negedge clk);
    check("bat_host_len", 32'(sent_q.size()), 32'd2);
    check("bat_host_done", 32'(init_done), 32'd1);
    check("bat_host_noack", 32'(ack_seen), 32'(acks_exp));

    fwd_byte(8'h08);
    fwd_byte(8'h01);
    fwd_byte(8'hFF);

    host_cmd(8'hF3, 0);

    run_init(0, 0, 0, 8'h03, 1'b1);
    check("start_beats_host", 32'(sent_q[0]), 32'hFF);

    for (int r = 0; r < 14; r++) begin
      fault = ($urandom_range(0, 2) == 0) ? int'($urandom_range(1, 4)) : 0;
      run_init(int'($urandom_range(0, 3)), int'($urandom_range(0, 3)), fault,
               8'($urandom), 1'b0);
    end

    run_init(0, 0, 0, 8'h00, 1'b0);
    for (int r = 0; r < 30; r++) begin
      if ($urandom_range(0, 1) == 1) begin
        cmd = 8'($urandom);
        exp_fwd_q.push_back(cmd);
        reply(cmd);
      end else begin
        host_cmd(8'($urandom), int'($urandom_range(0, 3)));
      end
    end
    repeat (3) @(negedge clk);
    check("fwd_queue_drained", 32'(exp_fwd_q.size()), 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
